// File: rtl/meas_frame_pkg.sv
// Shared types and constants for the measurement frame packer.
// Frame layout: two header bytes, sixteen data bytes, optional XOR checksum.
package meas_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_CSUM
  } state_t;

  localparam logic [7:0] HEADER0_DEF = 8'hAA;
  localparam logic [7:0] HEADER1_DEF = 8'h55;

  localparam int DATA_BYTES       = 16;
  localparam int FRAME_LEN_CSUM   = DATA_BYTES + 3;
  localparam int FRAME_LEN_NOCSUM = DATA_BYTES + 2;

  // idx 0 is bits 127:120 of the capture, i.e. fxCnt MSB.
  function automatic logic [7:0] byte_sel(input logic [127:0] words,
                                          input logic [3:0]   idx);
    logic [127:0] sh;
    sh = words >> {~idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/meas_frame_packer.sv
// Captures the four measurement words on done_sig and streams them as a
// framed byte sequence over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for done_sig, no byte offered
// HDR0  | offering first header byte
// HDR1  | offering second header byte
// DATA  | offering data byte idx (0..15), checksum accumulating
// CSUM  | offering XOR checksum of the data bytes
module meas_frame_packer
  import meas_frame_pkg::*;
#(
  parameter logic [7:0] HEADER0 = HEADER0_DEF,
  parameter logic [7:0] HEADER1 = HEADER1_DEF,
  parameter bit         CSUM_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        done_sig,
  input  logic [31:0] fxCnt,
  input  logic [31:0] fbaseCnt,
  input  logic [31:0] dutyCnt,
  input  logic [31:0] delayCnt,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        overrun
);

  state_t       state;
  logic [3:0]   idx;
  logic [127:0] cap;
  logic [7:0]   csum;
  logic         xfer;
  logic         last_byte;

  assign xfer      = byte_valid && byte_ready;
  assign last_byte = (state == ST_CSUM) ||
                     (state == ST_DATA && idx == 4'(DATA_BYTES - 1) && !CSUM_EN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cap        <= '0;
      csum       <= '0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_sig && (state == ST_IDLE || (xfer && last_byte))) begin
      // Capture also accepted on the final transfer so frames can run back-to-back.
      state      <= ST_HDR0;
      idx        <= '0;
      cap        <= {fxCnt, fbaseCnt, dutyCnt, delayCnt};
      csum       <= '0;
      byte_data  <= HEADER0;
      byte_valid <= 1'b1;
      busy       <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      if (done_sig) overrun <= 1'b1;
      if (xfer) begin
        case (state)
          ST_HDR0: begin
            state     <= ST_HDR1;
            byte_data <= HEADER1;
          end
          ST_HDR1: begin
            state     <= ST_DATA;
            idx       <= '0;
            byte_data <= byte_sel(cap, 4'd0);
          end
          ST_DATA: begin
            csum <= csum ^ byte_data;
            if (idx == 4'(DATA_BYTES - 1)) begin
              if (CSUM_EN) begin
                state     <= ST_CSUM;
                byte_data <= csum ^ byte_data;
              end else begin
                state      <= ST_IDLE;
                byte_data  <= 8'h00;
                byte_valid <= 1'b0;
                busy       <= 1'b0;
              end
            end else begin
              idx       <= idx + 4'd1;
              byte_data <= byte_sel(cap, idx + 4'd1);
            end
          end
          ST_CSUM: begin
            state      <= ST_IDLE;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/meas_frame_packer.md
Name: meas_frame_packer

Overview:
Downstream stage of the frequency/duty/delay measurement core. It captures the four 32-bit measurement results on the core's completion pulse and serialises them into a framed byte stream: header, 16 data bytes, checksum. The stream is handed byte-by-byte over a valid/ready handshake to the UART byte transmitter. This separates framing from bit-level UART timing and makes back-pressure explicit.

Parameters:
HEADER0, 8'hAA, first frame header byte
HEADER1, 8'h55, second frame header byte
CSUM_EN, 1, 1 = append XOR checksum byte (frame 19 bytes); 0 = omit it (frame 18 bytes)

Ports:
CLK  in  1  measurement clock (PLL output domain)
RST  in  1  reset
done_sig  in  1  one-cycle pulse from measurement core; results valid in the same cycle
fxCnt  in  32  signal-period count
fbaseCnt  in  32  reference-clock count
dutyCnt  in  32  high-time count
delayCnt  in  32  A-to-B delay count
byte_data  out  8  current frame byte
byte_valid  out  1  byte_data valid
byte_ready  in  1  UART transmitter accepts the byte
busy  out  1  frame in progress
overrun  out  1  sticky: a done_sig pulse was dropped

Interface: one clock, CLK; reset RST is asynchronous and active-high.

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE; byte_valid=0, byte_data=8'h00, busy=0, overrun=0; capture register and checksum cleared. The current frame is abandoned and no partial resume occurs.
- Transfer rule: a byte is transferred on a CLK edge where byte_valid && byte_ready. While byte_valid=1 and byte_ready=0, byte_data holds stable. byte_valid never drops without a transfer, except on reset.
- Capture: in IDLE, done_sig=1 latches all four words in that edge's register. Next cycle: state HDR0, byte_valid=1, busy=1. Latency from done_sig to first valid byte is 1 cycle.
- FSM:
  - IDLE -> HDR0 on done_sig.
  - HDR0 -> HDR1 on transfer.
  - HDR1 -> DATA (idx=0) on transfer.
  - DATA: idx 0..15 on transfer, idx increments; idx=15 transfer -> CSUM if CSUM_EN, else IDLE.
  - CSUM -> IDLE on transfer.
- Data order: fxCnt, fbaseCnt, dutyCnt, delayCnt. Each word is sent MSB byte first; idx[3:2] selects the word and idx[1:0] selects the byte (0 = bits 31:24).
- Checksum: XOR of the 16 data bytes only, headers excluded. It is accumulated on each DATA transfer and cleared on capture.
- busy = 1 in every state except IDLE.
- done_sig while busy: the pulse is dropped, the captured words are unchanged, and overrun is set. overrun stays set until reset or the next successful capture, which clears it in the same edge.
- Simultaneous case: done_sig in the same cycle as the final byte transfer (CSUM, or idx=15 with CSUM_EN=0) counts as a successful capture. The next frame starts with HDR0 valid the following cycle, with no idle gap and overrun not set.
- byte_ready while byte_valid=0 is ignored.

Decomposition:
- Package meas_frame_pkg holds:
  - FSM state encoding (IDLE, HDR0, HDR1, DATA, CSUM)
  - default header constants
  - DATA_BYTES=16
  - frame-length constants for CSUM_EN = 0 and 1
- No sub-module is required. The byte-select mux (128-bit capture to 8-bit by idx) may be a function in the package. The UART bit engine stays a separate existing block.

Test Plan:
- Basic frame: fxCnt=32'h12345678, fbaseCnt=32'h9ABCDEF0, dutyCnt=0, delayCnt=32'h000000A5, byte_ready tied 1 -> 19 consecutive bytes AA 55 12 34 56 78 9A BC DE F0 00 00 00 00 00 00 00 A5 A5. First byte appears 1 cycle after done_sig; busy falls after the 19th transfer.
- Back-pressure: same data, byte_ready toggled pseudo-randomly -> identical byte sequence, byte_data stable whenever valid&&!ready, no byte lost or duplicated.
- Overrun: second done_sig with fxCnt=32'hFFFFFFFF during DATA idx=5 -> current frame completes with the original values, overrun=1. The next done_sig in IDLE clears overrun and sends the new frame.
- Back-to-back: done_sig coincident with the CSUM transfer -> HDR0 (AA) valid on the next cycle, overrun=0.
- Reset mid-frame: assert RST during DATA idx=9 with byte_ready=0 -> byte_valid, busy and overrun go 0 immediately (async). After release, a fresh done_sig yields a complete frame starting at AA.
- CSUM_EN=0: all inputs 32'h00000001 -> 18 bytes AA 55 00 00 00 01 (x4), with no trailing checksum.
